// File: rtl/exe_pc_unit_ras_if.sv
// Bundles the execute-stage control inputs and the PC/operand/RAS outputs
// of exe_pc_unit_ras. The master side drives instruction controls, and the slave side is the PC unit.
interface exe_pc_unit_ras_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 28,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 8
);
  localparam int CNT_BITS = $clog2(RAS_DEPTH) + 1;

  logic                in_valid;
  logic                stall;
  logic [1:0]          pcsource;
  logic                alumm;
  logic                shift;
  logic                mtoreg;
  logic                jal;
  logic [DATA_W-1:0]   shift_data;
  logic [ADDR_W-1:0]   addr_data;
  logic [DATA_W-1:0]   imm_data;
  logic [DATA_W-1:0]   dout_mem;
  logic [DATA_W-1:0]   alu_doutr;
  logic [DATA_W-1:0]   rd_douta;
  logic [DATA_W-1:0]   rd_doutb;

  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   pc_next;
  logic [DATA_W-1:0]   alu_dina;
  logic [DATA_W-1:0]   alu_dinb;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   ras_top;
  logic [CNT_BITS-1:0] ras_count;
  logic                ras_hit;
  logic [CNT_W-1:0]    ras_miss_cnt;

  modport master (
    output in_valid, stall, pcsource, alumm, shift, mtoreg, jal,
           shift_data, addr_data, imm_data, dout_mem, alu_doutr, rd_douta, rd_doutb,
    input  pc, pc_next, alu_dina, alu_dinb, wr_data, ras_top, ras_count, ras_hit, ras_miss_cnt
  );

  modport slave (
    input  in_valid, stall, pcsource, alumm, shift, mtoreg, jal,
           shift_data, addr_data, imm_data, dout_mem, alu_doutr, rd_douta, rd_doutb,
    output pc, pc_next, alu_dina, alu_dinb, wr_data, ras_top, ras_count, ras_hit, ras_miss_cnt
  );
endinterface

// File: rtl/exe_pc_unit_ras.sv
// Execute-stage PC register, next-PC select, operand/write-back muxes and a
// circular return-address stack that scores register jumps as hits or misses.
module exe_pc_unit_ras #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 28,
  parameter int PC_INC    = 4,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst,
  exe_pc_unit_ras_if.slave  bus
);
  localparam int PTR_W    = $clog2(RAS_DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JR     = 2'b10,
    PC_JUMP   = 2'b11
  } pcsrc_e;

  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                hit_q, hit_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic [DATA_W-1:0]   ras_q [RAS_DEPTH];
  logic [DATA_W-1:0]   ras_d [RAS_DEPTH];

  logic                advance;
  logic                is_jr;
  logic [DATA_W-1:0]   pc_plus;
  logic [DATA_W-1:0]   pc_next;
  logic [DATA_W-1:0]   ras_top;

  assign advance = bus.in_valid & ~bus.stall;
  assign is_jr   = (pcsrc_e'(bus.pcsource) == PC_JR);
  assign pc_plus = pc_q + DATA_W'(PC_INC);
  assign ras_top = (cnt_q != '0) ? ras_q[ptr_q] : '0;

  always_comb begin
    unique case (pcsrc_e'(bus.pcsource))
      PC_SEQ:    pc_next = pc_plus;
      PC_BRANCH: pc_next = pc_plus + (bus.imm_data << 2);
      PC_JR:     pc_next = bus.rd_douta;
      PC_JUMP:   pc_next = {pc_q[DATA_W-1:ADDR_W], bus.addr_data};
      default:   pc_next = pc_plus;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    hit_d  = 1'b0;
    miss_d = miss_q;
    ras_d  = ras_q;
    if (advance) begin
      pc_d = pc_next;
      if (bus.jal && !is_jr) begin
        // Push wraps the pointer, so a full stack overwrites its oldest entry.
        ptr_d        = ptr_q + 1'b1;
        ras_d[ptr_d] = pc_plus;
        if (cnt_q != CNT_BITS'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
      end else if (is_jr) begin
        hit_d = (cnt_q != '0) && (bus.rd_douta == ras_top);
        if (!hit_d && (miss_q != '1)) miss_d = miss_q + 1'b1;
        if (bus.jal) begin
          ras_d[ptr_q] = pc_plus;
          if (cnt_q == '0) cnt_d = CNT_BITS'(1);
        end else if (cnt_q != '0) begin
          ptr_d = ptr_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // NOTE: the RAS array is reset along with the control state so ras_top never exposes stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= DATA_W'(RESET_PC);
      ptr_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= '0;
      ras_q  <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
      ras_q  <= ras_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_next      = pc_next;
  assign bus.alu_dina     = bus.shift ? bus.shift_data : bus.rd_douta;
  assign bus.alu_dinb     = bus.alumm ? bus.imm_data : bus.rd_doutb;
  assign bus.wr_data      = bus.jal ? pc_plus : (bus.mtoreg ? bus.dout_mem : bus.alu_doutr);
  assign bus.ras_top      = ras_top;
  assign bus.ras_count    = cnt_q;
  assign bus.ras_hit      = hit_q;
  assign bus.ras_miss_cnt = miss_q;
endmodule

// File: tb/tb_exe_pc_unit_ras.sv
// Directed bench for exe_pc_unit_ras: stimulus queues expectations tagged with
// a cycle number, and a negedge monitor pops and compares them against the DUT.
module tb_exe_pc_unit_ras;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 28;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_pc_unit_ras_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) bus();

  exe_pc_unit_ras #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_INC(4), .RESET_PC(0),
    .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {S_PC, S_PCN, S_WR, S_DINA, S_DINB, S_TOP, S_CNT, S_HIT, S_MISS} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_PC:    return bus.pc;
      S_PCN:   return bus.pc_next;
      S_WR:    return bus.wr_data;
      S_DINA:  return bus.alu_dina;
      S_DINB:  return bus.alu_dinb;
      S_TOP:   return bus.ras_top;
      S_CNT:   return 32'(bus.ras_count);
      S_HIT:   return 32'(bus.ras_hit);
      S_MISS:  return 32'(bus.ras_miss_cnt);
      default: return 'x;
    endcase
  endfunction

  // Monitor: compares everything due in the current cycle, away from the edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc || sample(e.sig) !== e.val) begin
        failures++;
        $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, sample(e.sig), e.val);
      end
    end
  end

  task automatic expect_now(sig_e s, logic [31:0] v, string n);
    sb.push_back('{cyc, s, v, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(logic valid, logic stl, logic [1:0] src, logic lnk);
    bus.in_valid = valid;
    bus.stall    = stl;
    bus.pcsource = src;
    bus.jal      = lnk;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] tops [4];
    tops = '{32'h54, 32'h44, 32'h34, 32'h24};

    rst = 1'b1;
    ctrl(1'b1, 1'b0, 2'b00, 1'b0);
    bus.alumm = 1'b0; bus.shift = 1'b0; bus.mtoreg = 1'b0;
    bus.shift_data = '0; bus.addr_data = '0; bus.imm_data = '0; bus.dout_mem = '0;
    bus.alu_doutr = '0; bus.rd_douta = '0; bus.rd_doutb = '0;
    tick();

    // Reset state and sequential flow.
    rst = 1'b0;
    expect_now(S_PC, 32'h0, "reset_pc");
    expect_now(S_CNT, 32'h0, "reset_count");
    expect_now(S_HIT, 32'h0, "reset_hit");
    expect_now(S_MISS, 32'h0, "reset_miss");
    expect_now(S_TOP, 32'h0, "reset_top");
    expect_now(S_PCN, 32'h4, "seq_pc_next");
    tick();
    expect_now(S_PC, 32'h4, "seq_pc_4");
    tick();
    expect_now(S_PC, 32'h8, "seq_pc_8");
    tick();
    expect_now(S_PC, 32'hC, "seq_pc_12");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ctrl(1'b0, 1'b0, 2'b00, 1'b0);
    expect_now(S_PC, 32'h0, "midrun_reset_pc");
    expect_now(S_CNT, 32'h0, "midrun_reset_count");
    tick();

    // Bubble holds pc; then jump to 0x100 and exercise the branch under stall.
    expect_now(S_PC, 32'h0, "bubble_hold_pc");
    ctrl(1'b1, 1'b0, 2'b11, 1'b0);
    bus.addr_data = 28'h100;
    expect_now(S_PCN, 32'h100, "jump_pc_next");
    tick();
    ctrl(1'b1, 1'b1, 2'b01, 1'b0);
    bus.imm_data = 32'hFFFF_FFFE;
    expect_now(S_PC, 32'h100, "stall_pc_a");
    expect_now(S_PCN, 32'hFC, "branch_pc_next");
    tick();
    expect_now(S_PC, 32'h100, "stall_pc_b");
    tick();
    bus.stall = 1'b0;
    expect_now(S_PC, 32'h100, "stall_pc_c");
    tick();
    expect_now(S_PC, 32'hFC, "branch_taken_pc");

    // jal + absolute jump, then a matching jr.
    ctrl(1'b1, 1'b0, 2'b11, 1'b0);
    bus.addr_data = 28'h40;
    tick();
    ctrl(1'b1, 1'b0, 2'b11, 1'b1);
    bus.addr_data = 28'h800;
    expect_now(S_PC, 32'h40, "jal_pc");
    expect_now(S_WR, 32'h44, "jal_link");
    expect_now(S_PCN, 32'h800, "jal_pc_next");
    tick();
    ctrl(1'b1, 1'b0, 2'b10, 1'b0);
    bus.rd_douta = 32'h44;
    expect_now(S_PC, 32'h800, "jal_target_pc");
    expect_now(S_TOP, 32'h44, "push_top");
    expect_now(S_CNT, 32'h1, "push_count");
    expect_now(S_PCN, 32'h44, "jr_pc_next");
    tick();
    ctrl(1'b1, 1'b0, 2'b11, 1'b0);
    bus.addr_data = 28'h10;
    expect_now(S_HIT, 32'h1, "jr_hit");
    expect_now(S_CNT, 32'h0, "jr_pop_count");
    expect_now(S_TOP, 32'h0, "empty_top");
    expect_now(S_PC, 32'h44, "jr_pc");
    tick();

    // Five nested pushes into a 4-deep stack, then pops.
    for (int i = 1; i <= 5; i++) begin
      ctrl(1'b1, 1'b0, 2'b11, 1'b1);
      bus.addr_data = ADDR_W'((i + 1) * 16);
      expect_now(S_PC, 32'(i * 16), "nest_pc");
      expect_now(S_WR, 32'(i * 16 + 4), "nest_link");
      if (i == 1) expect_now(S_HIT, 32'h0, "hit_pulse_cleared");
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      ctrl(1'b1, 1'b0, 2'b10, 1'b0);
      bus.rd_douta = tops[k];
      expect_now(S_TOP, tops[k], "nest_top");
      expect_now(S_CNT, 32'(4 - k), "nest_count");
      if (k > 0) expect_now(S_HIT, 32'h1, "nest_hit");
      tick();
    end
    bus.rd_douta = 32'h14;
    expect_now(S_HIT, 32'h1, "nest_hit_last");
    expect_now(S_CNT, 32'h0, "nest_empty_count");
    expect_now(S_TOP, 32'h0, "nest_empty_top");
    expect_now(S_MISS, 32'h0, "miss_before_empty_pop");
    tick();
    expect_now(S_HIT, 32'h0, "empty_pop_hit");
    expect_now(S_MISS, 32'h1, "empty_pop_miss");
    expect_now(S_CNT, 32'h0, "empty_pop_count");
    expect_now(S_PC, 32'h14, "empty_pop_pc");

    // Miss counter saturation.
    bus.rd_douta = 32'h1234;
    for (int k = 0; k < 300; k++) begin
      if (k == 100) expect_now(S_MISS, 32'd101, "miss_count_101");
      tick();
    end
    expect_now(S_MISS, 32'd255, "miss_saturated");
    expect_now(S_PC, 32'h1234, "miss_jr_pc");

    // Two pushes then a jalr that matches the top.
    ctrl(1'b1, 1'b0, 2'b11, 1'b0);
    bus.addr_data = 28'h200;
    tick();
    ctrl(1'b1, 1'b0, 2'b11, 1'b1);
    bus.addr_data = 28'h300;
    expect_now(S_PC, 32'h200, "jalr_setup_pc");
    tick();
    bus.addr_data = 28'h400;
    tick();
    ctrl(1'b1, 1'b0, 2'b10, 1'b1);
    bus.rd_douta = 32'h304;
    expect_now(S_PC, 32'h400, "jalr_pc");
    expect_now(S_CNT, 32'h2, "jalr_pre_count");
    expect_now(S_TOP, 32'h304, "jalr_pre_top");
    expect_now(S_WR, 32'h404, "jalr_link");
    expect_now(S_PCN, 32'h304, "jalr_pc_next");
    tick();

    // Bubble cycle with operand muxes selecting the alternate sources.
    ctrl(1'b0, 1'b0, 2'b00, 1'b0);
    bus.shift = 1'b1; bus.shift_data = 32'hA5;
    bus.alumm = 1'b1; bus.imm_data = 32'h5A;
    bus.mtoreg = 1'b1; bus.dout_mem = 32'hDEAD; bus.alu_doutr = 32'hBEEF;
    bus.rd_douta = 32'h11; bus.rd_doutb = 32'h22;
    expect_now(S_HIT, 32'h1, "jalr_hit");
    expect_now(S_CNT, 32'h2, "jalr_count");
    expect_now(S_TOP, 32'h404, "jalr_top");
    expect_now(S_PC, 32'h304, "jalr_target_pc");
    expect_now(S_MISS, 32'd255, "jalr_miss_held");
    expect_now(S_DINA, 32'hA5, "dina_shift");
    expect_now(S_DINB, 32'h5A, "dinb_imm");
    expect_now(S_WR, 32'hDEAD, "wr_mem");
    tick();
    bus.shift = 1'b0; bus.alumm = 1'b0; bus.mtoreg = 1'b0;
    expect_now(S_HIT, 32'h0, "bubble_clears_hit");
    expect_now(S_PC, 32'h304, "bubble_pc_hold");
    expect_now(S_DINA, 32'h11, "dina_reg");
    expect_now(S_DINB, 32'h22, "dinb_reg");
    expect_now(S_WR, 32'hBEEF, "wr_alu");
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_pc_unit_ras.md
Name: exe_pc_unit_ras

Overview:
- Parametrised execute-stage control block for the single-cycle CPU.
- Holds the architectural PC register and computes next-PC for sequential, branch, register-jump and absolute-jump flow.
- Muxes ALU operands and the register-file write-back data, including the link address for jal.
- Adds a circular return-address stack (RAS) with hit/miss monitoring on register jumps, for profiling and for later prediction work.

Parameters:
- DATA_W, 32, datapath and PC width.
- ADDR_W, 28, width of the jump-address field (the upper DATA_W-ADDR_W PC bits are kept).
- PC_INC, 4, sequential PC increment in bytes.
- RESET_PC, 0, PC value after reset.
- RAS_DEPTH, 4, RAS entries; must be a power of 2 and at least 2.
- CNT_W, 8, width of the miss counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  current instruction is valid.
- stall  in  1  hold all state.
- pcsource  in  2  00 seq, 01 branch, 10 jr, 11 jump.
- alumm  in  1  select imm_data for alu_dinb.
- shift  in  1  select shift_data for alu_dina.
- mtoreg  in  1  select dout_mem for wr_data.
- jal  in  1  link: write PC+PC_INC and push to RAS.
- shift_data  in  DATA_W  shift amount operand.
- addr_data  in  ADDR_W  jump field, already shifted left by 2.
- imm_data  in  DATA_W  sign-extended immediate.
- dout_mem  in  DATA_W  data-memory read data.
- alu_doutr  in  DATA_W  ALU result.
- rd_douta  in  DATA_W  register-file port A.
- rd_doutb  in  DATA_W  register-file port B.
- pc  out  DATA_W  PC register.
- pc_next  out  DATA_W  combinational next-PC.
- alu_dina  out  DATA_W  combinational.
- alu_dinb  out  DATA_W  combinational.
- wr_data  out  DATA_W  combinational write-back data.
- ras_top  out  DATA_W  top RAS entry; 0 when empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries.
- ras_hit  out  1  registered one-cycle pulse: last jr matched RAS.
- ras_miss_cnt  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - pc=RESET_PC.
  - RAS pointer, ras_count, ras_hit and ras_miss_cnt all go to 0.
  - RAS entries go to 0.
  - rst has priority over stall and in_valid.
- advance = in_valid & ~stall. All sequential state updates only on advance, except ras_hit, which is cleared on every non-advance cycle.
- pc_next, all arithmetic modulo 2^DATA_W:
  - 00: pc+PC_INC.
  - 01: pc+PC_INC+(imm_data<<2).
  - 10: rd_douta.
  - 11: {pc[DATA_W-1:ADDR_W], addr_data}.
- On advance, pc<=pc_next. If in_valid=0 (bubble), pc holds.
- Operand and write-back muxes:
  - alu_dina = shift ? shift_data : rd_douta.
  - alu_dinb = alumm ? imm_data : rd_doutb.
  - wr_data priority: jal → pc+PC_INC; else mtoreg → dout_mem; else alu_doutr.
- RAS is a circular buffer with a top pointer.
  - Push (advance & jal & pcsource!=10):
    - Write pc+PC_INC at top+1 and advance the pointer.
    - ras_count increments, saturating at RAS_DEPTH.
    - When full, the oldest entry is silently overwritten.
  - Pop (advance & pcsource==10 & ~jal):
    - If ras_count>0: ras_hit<=(rd_douta==ras_top), then retreat the pointer and decrement ras_count.
    - If ras_count==0: no pointer change, ras_hit<=0.
    - Either case: on a miss, ras_miss_cnt increments, saturating at all-ones.
  - jalr (advance & pcsource==10 & jal):
    - Compare and count hit/miss exactly as for a pop.
    - Then replace the top entry with pc+PC_INC; ras_count is unchanged.
    - If the RAS is empty, ras_count becomes 1 instead.
  - ras_hit is cleared on any cycle that is not a pop or jalr.
- ras_top is combinational from the current pointer; it reads 0 when ras_count==0.
- stall=1 freezes pc and RAS contents; the combinational outputs still follow the inputs.

Test Plan:
- Reset, then 3 cycles with pcsource=00 and in_valid=1 → pc=0,4,8,12. Assert rst mid-run → next edge pc=0 and ras_count=0.
- pc=0x100, pcsource=01, imm_data=0xFFFFFFFE → pc_next=0xFC. With stall=1 for 2 cycles pc stays 0x100; releasing stall gives pc=0xFC.
- pc=0x40, jal=1, pcsource=11, addr_data=0x0000800 → wr_data=0x44, next pc=0x800, ras_top=0x44, ras_count=1. Then pcsource=10, rd_douta=0x44 → ras_hit=1, ras_count=0, pc=0x44.
- Five nested jal pushes with RAS_DEPTH=4, at pc 0x10,0x20,0x30,0x40,0x50 → ras_count=4. The next pops with matching rd_douta give hits for 0x54,0x44,0x34,0x24. A fifth pop on the empty RAS → ras_hit=0, ras_miss_cnt=1.
- Pop with rd_douta≠ras_top repeated 300 times (CNT_W=8) → ras_miss_cnt saturates at 255.
- jalr (jal=1, pcsource=10) with ras_count=2 and a matching top → ras_hit=1, ras_count stays 2, ras_top=pc+4. Operand muxes: shift=1 → alu_dina=shift_data; alumm=1 → alu_dinb=imm_data; mtoreg=1, jal=0 → wr_data=dout_mem.
